// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/sub: the operand is split into STAGES segments,
// each resolved by 16-bit CLA slices under a slice-level lookahead, carry registered between segments.
module cla_pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_ci,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             out_ov,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NS   = SEG / 16;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > 4 || (WIDTH % (16 * STAGES)) != 0) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH/STAGES must give a segment width that is a multiple of 16");
    end

    // 4-bit lookahead unit: returns {group_g, group_p, carries into positions 3..0}
    function automatic logic [5:0] clu4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p, c};
    endfunction

    // 16-bit slice as two CLU levels: returns {slice_g, slice_p, sum}
    function automatic logic [17:0] cla16(input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  ng;
        logic [3:0]  np;
        logic [3:0]  nc;
        logic [5:0]  r;
        logic        sg;
        logic        sp;
        g = a & b;
        p = a ^ b;
        for (int q = 0; q < 4; q++) begin
            r     = clu4(g[4*q +: 4], p[4*q +: 4], 1'b0);
            ng[q] = r[5];
            np[q] = r[4];
        end
        r  = clu4(ng, np, ci);
        nc = r[3:0];
        sg = r[5];
        sp = r[4];
        for (int q = 0; q < 4; q++) begin
            r            = clu4(g[4*q +: 4], p[4*q +: 4], nc[q]);
            c[4*q +: 4]  = r[3:0];
        end
        return {sg, sp, p ^ c};
    endfunction

    // One segment: slice G/P feed a lookahead over slices, then slices resolve sums
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                             input logic ci);
        logic [NS-1:0]  sg;
        logic [NS-1:0]  sp;
        logic [NS:0]    sc;
        logic [17:0]    r;
        logic [SEG-1:0] s;
        for (int j = 0; j < NS; j++) begin
            r     = cla16(a[16*j +: 16], b[16*j +: 16], 1'b0);
            sg[j] = r[17];
            sp[j] = r[16];
        end
        sc[0] = ci;
        for (int j = 0; j < NS; j++) begin
            sc[j+1] = sg[j] | (sp[j] & sc[j]);
        end
        for (int j = 0; j < NS; j++) begin
            r              = cla16(a[16*j +: 16], b[16*j +: 16], sc[j]);
            s[16*j +: 16]  = r[15:0];
        end
        return {sc[NS], s};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = in_b ^ {WIDTH{in_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_W = (k + 1) * SEG;
        localparam int HI_W = WIDTH - LO_W;

        logic             v_in;
        logic [TAG_W-1:0] tag_in;
        logic [SEG-1:0]   a_seg;
        logic [SEG-1:0]   b_seg;
        logic             c_in;
        logic [SEG:0]     seg_res;
        logic [LO_W-1:0]  lo_d;

        logic             v_q;
        logic [TAG_W-1:0] tag_q;
        logic [LO_W-1:0]  lo_q;
        logic             c_q;

        if (k == 0) begin : g_src
            assign v_in   = in_valid;
            assign tag_in = in_tag;
            assign a_seg  = in_a[SEG-1:0];
            assign b_seg  = b_eff[SEG-1:0];
            assign c_in   = in_sub | in_ci;
            assign lo_d   = seg_res[SEG-1:0];
        end else begin : g_src
            assign v_in   = g_stage[k-1].v_q;
            assign tag_in = g_stage[k-1].tag_q;
            assign a_seg  = g_stage[k-1].g_hi.a_hi_q[SEG-1:0];
            assign b_seg  = g_stage[k-1].g_hi.b_hi_q[SEG-1:0];
            assign c_in   = g_stage[k-1].c_q;
            assign lo_d   = {seg_res[SEG-1:0], g_stage[k-1].lo_q};
        end

        assign seg_res = seg_add(a_seg, b_seg, c_in);

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                tag_q <= '0;
                lo_q  <= '0;
                c_q   <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    tag_q <= tag_in;
                    lo_q  <= lo_d;
                    c_q   <= seg_res[SEG];
                end
            end
        end

        // Operand segments not yet consumed ride along until their stage
        if (HI_W > 0) begin : g_hi
            logic [HI_W-1:0] a_hi_d;
            logic [HI_W-1:0] b_hi_d;
            logic [HI_W-1:0] a_hi_q;
            logic [HI_W-1:0] b_hi_q;

            if (k == 0) begin : g_hsrc
                assign a_hi_d = in_a[WIDTH-1:SEG];
                assign b_hi_d = b_eff[WIDTH-1:SEG];
            end else begin : g_hsrc
                assign a_hi_d = g_stage[k-1].g_hi.a_hi_q[HI_W+SEG-1:SEG];
                assign b_hi_d = g_stage[k-1].g_hi.b_hi_q[HI_W+SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (adv && v_in) begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end
    end

    // Carry into the MSB recovered from its sum bit: c[W-1] = a ^ b ^ s at bit W-1
    logic c_msb;
    logic ov_q;
    logic zero_q;

    assign c_msb = g_stage[LAST].a_seg[SEG-1] ^ g_stage[LAST].b_seg[SEG-1] ^
                   g_stage[LAST].seg_res[SEG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv && g_stage[LAST].v_in) begin
            ov_q   <= c_msb ^ g_stage[LAST].seg_res[SEG];
            zero_q <= ~|g_stage[LAST].lo_d;
        end
    end

    assign out_valid = g_stage[LAST].v_q;
    assign out_s     = g_stage[LAST].lo_q;
    assign out_co    = g_stage[LAST].c_q;
    assign out_tag   = g_stage[LAST].tag_q;
    assign out_ov    = ov_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vector table, reset-in-flight sequence,
// random streaming with backpressure against an arithmetic reference model.
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        m_in_valid, m_in_ready, m_in_sub, m_in_ci, m_out_valid, m_out_ready;
    logic        m_out_co, m_out_ov, m_out_zero;
    logic [63:0] m_in_a, m_in_b, m_out_s;
    logic [4:0]  m_in_tag, m_out_tag;

    logic         w_in_valid, w_in_ready, w_in_sub, w_in_ci, w_out_valid, w_out_ready;
    logic         w_out_co, w_out_ov, w_out_zero;
    logic [127:0] w_in_a, w_in_b, w_out_s;
    logic [4:0]   w_in_tag, w_out_tag;

    logic        n_in_valid, n_in_ready, n_in_sub, n_in_ci, n_out_valid, n_out_ready;
    logic        n_out_co, n_out_ov, n_out_zero;
    logic [31:0] n_in_a, n_in_b, n_out_s;
    logic [4:0]  n_in_tag, n_out_tag;

    cla_pipe_adder #(.WIDTH(64), .STAGES(2), .TAG_W(5)) u_main (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_a(m_in_a), .in_b(m_in_b), .in_sub(m_in_sub), .in_ci(m_in_ci), .in_tag(m_in_tag),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_s(m_out_s), .out_co(m_out_co),
        .out_ov(m_out_ov), .out_zero(m_out_zero), .out_tag(m_out_tag));

    cla_pipe_adder #(.WIDTH(128), .STAGES(4), .TAG_W(5)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_sub(w_in_sub), .in_ci(w_in_ci), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_s(w_out_s), .out_co(w_out_co),
        .out_ov(w_out_ov), .out_zero(w_out_zero), .out_tag(w_out_tag));

    cla_pipe_adder #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_a(n_in_a), .in_b(n_in_b), .in_sub(n_in_sub), .in_ci(n_in_ci), .in_tag(n_in_tag),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_s(n_out_s), .out_co(n_out_co),
        .out_ov(n_out_ov), .out_zero(n_out_zero), .out_tag(n_out_tag));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] s;
        logic         co;
        logic         ov;
        logic         zero;
    } res_t;

    // Plain-integer reference: wide add, then flags from sign rules
    function automatic res_t ref_add(input int w, input logic [127:0] a, input logic [127:0] b,
                                     input logic sub, input logic ci);
        logic [127:0] mask;
        logic [127:0] be;
        logic [128:0] full;
        res_t         r;
        mask   = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        be     = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, be} + {128'd0, (sub | ci)};
        r.s    = full[127:0] & mask;
        r.co   = full[w];
        r.ov   = (a[w-1] == be[w-1]) && (r.s[w-1] != a[w-1]);
        r.zero = (r.s == 128'd0);
        return r;
    endfunction

    task automatic run_main(input logic [63:0] a, input logic [63:0] b, input logic sub,
                            input logic ci, input logic [4:0] tag, output int lat);
        @(posedge clk); #1;
        m_in_valid = 1'b1; m_in_a = a; m_in_b = b; m_in_sub = sub; m_in_ci = ci;
        m_in_tag = tag; m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!m_out_valid && lat < 10) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic run_wide(input logic [127:0] a, input logic [127:0] b, input logic sub,
                            input logic ci, input logic [4:0] tag, output int lat);
        @(posedge clk); #1;
        w_in_valid = 1'b1; w_in_a = a; w_in_b = b; w_in_sub = sub; w_in_ci = ci;
        w_in_tag = tag; w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!w_out_valid && lat < 10) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic run_narrow(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input logic ci, input logic [4:0] tag, output int lat);
        @(posedge clk); #1;
        n_in_valid = 1'b1; n_in_a = a; n_in_b = b; n_in_sub = sub; n_in_ci = ci;
        n_in_tag = tag; n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!n_out_valid && lat < 10) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        ci;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        zero;
        logic [4:0]  tag;
    } exp_t;

    initial begin
        vec_t  vecs [9];
        exp_t  q [$];
        exp_t  e;
        res_t  r;
        int    lat;
        int    issued;
        int    popped;
        int    cyc;
        logic  acc;
        logic [127:0] ra;
        logic [127:0] rb;
        logic  rsub;
        logic  rci;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{64'h1, 64'h2, 1'b0, 1'b1, 64'h4, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{64'h5, 64'h5, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        m_in_valid = 0; m_in_a = '0; m_in_b = '0; m_in_sub = 0; m_in_ci = 0; m_in_tag = '0; m_out_ready = 0;
        w_in_valid = 0; w_in_a = '0; w_in_b = '0; w_in_sub = 0; w_in_ci = 0; w_in_tag = '0; w_out_ready = 0;
        n_in_valid = 0; n_in_a = '0; n_in_b = '0; n_in_sub = 0; n_in_ci = 0; n_in_tag = '0; n_out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_out_s", m_out_s, 0);
        check("rst_out_zero", m_out_zero, 0);
        check("rst_in_ready", m_in_ready, 1);
        check("rst_wide_valid", w_out_valid, 0);
        check("rst_narrow_zero", n_out_zero, 0);

        for (int i = 0; i < 9; i++) begin
            run_main(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci, 5'(i + 1), lat);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_s", i), m_out_s, vecs[i].s);
            check($sformatf("vec%0d_co", i), m_out_co, vecs[i].co);
            check($sformatf("vec%0d_ov", i), m_out_ov, vecs[i].ov);
            check($sformatf("vec%0d_zero", i), m_out_zero, vecs[i].zero);
            check($sformatf("vec%0d_tag", i), m_out_tag, 5'(i + 1));
        end

        // Reset with two ops in flight
        @(posedge clk); #1;
        m_out_ready = 1'b0; m_in_valid = 1'b1; m_in_a = 64'h10; m_in_b = 64'h20;
        m_in_sub = 1'b0; m_in_ci = 1'b0; m_in_tag = 5'd3;
        @(posedge clk); #1;
        m_in_a = 64'h30; m_in_tag = 5'd4;
        @(posedge clk); #1;
        m_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("midrst_inflight_valid", m_out_valid, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", m_out_valid, 0);
        check("midrst_out_s", m_out_s, 0);
        check("midrst_out_co", m_out_co, 0);
        check("midrst_out_ov", m_out_ov, 0);
        check("midrst_out_zero", m_out_zero, 0);
        check("midrst_out_tag", m_out_tag, 0);
        check("midrst_in_ready", m_in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_dropped_valid", m_out_valid, 0);
        end
        run_main(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 5'd9, lat);
        check("postrst_latency", lat, 2);
        check("postrst_s", m_out_s, 64'h0000_0001_0000_0000);
        check("postrst_tag", m_out_tag, 5'd9);

        // Random streaming with backpressure; every valid output compared to the queue head
        issued = 0; popped = 0; cyc = 0;
        while (popped < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (m_out_valid) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_valid", m_out_valid, 0);
                end else begin
                    check("rand_s", m_out_s, q[0].s);
                    check("rand_co", m_out_co, q[0].co);
                    check("rand_ov", m_out_ov, q[0].ov);
                    check("rand_zero", m_out_zero, q[0].zero);
                    check("rand_tag", m_out_tag, q[0].tag);
                    if (m_out_ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            acc = m_in_valid && m_in_ready;
            if (acc) begin
                r = ref_add(64, {64'd0, m_in_a}, {64'd0, m_in_b}, m_in_sub, m_in_ci);
                e.s = r.s[63:0]; e.co = r.co; e.ov = r.ov; e.zero = r.zero; e.tag = m_in_tag;
                q.push_back(e);
            end
            @(posedge clk); #1;
            if (acc) m_in_valid = 1'b0;
            if (!m_in_valid && issued < 100 && $urandom_range(0, 3) != 0) begin
                m_in_a   = {$urandom, $urandom};
                m_in_b   = ($urandom_range(0, 7) == 0) ? m_in_a : {$urandom, $urandom};
                m_in_sub = 1'($urandom_range(0, 1));
                m_in_ci  = 1'($urandom_range(0, 1));
                m_in_tag = 5'($urandom_range(0, 31));
                m_in_valid = 1'b1;
                issued++;
            end
            m_out_ready = 1'($urandom_range(0, 1));
        end
        check("rand_popped", popped, 100);
        check("rand_leftover", q.size(), 0);
        m_out_ready = 1'b1;

        // WIDTH=128, STAGES=4
        run_wide(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 5'd1, lat);
        check("wide_latency", lat, 4);
        check("wide_seg_carry_s", w_out_s, 128'h0000_0000_0000_0000_0000_0001_0000_0000);
        check("wide_seg_carry_co", w_out_co, 0);
        run_wide(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 5'd2, lat);
        check("wide_ripple3_s", w_out_s, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
        run_wide({128{1'b1}}, 128'h1, 1'b0, 1'b0, 5'd3, lat);
        check("wide_wrap_s", w_out_s, 128'h0);
        check("wide_wrap_co", w_out_co, 1);
        check("wide_wrap_zero", w_out_zero, 1);
        check("wide_wrap_tag", w_out_tag, 5'd3);
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rsub = 1'($urandom_range(0, 1));
            rci  = 1'($urandom_range(0, 1));
            r = ref_add(128, ra, rb, rsub, rci);
            run_wide(ra, rb, rsub, rci, 5'(i), lat);
            check("wide_rand_s", w_out_s, r.s);
            check("wide_rand_flags", {w_out_co, w_out_ov, w_out_zero}, {r.co, r.ov, r.zero});
        end

        // WIDTH=32, STAGES=1
        run_narrow(32'h0, 32'h0, 1'b1, 1'b0, 5'd7, lat);
        check("narrow_latency", lat, 1);
        check("narrow_sub0_s", n_out_s, 32'h0);
        check("narrow_sub0_co", n_out_co, 1);
        check("narrow_sub0_zero", n_out_zero, 1);
        check("narrow_sub0_ov", n_out_ov, 0);
        check("narrow_sub0_tag", n_out_tag, 5'd7);
        for (int i = 0; i < 20; i++) begin
            ra = {96'd0, $urandom};
            rb = {96'd0, $urandom};
            rsub = 1'($urandom_range(0, 1));
            rci  = 1'($urandom_range(0, 1));
            r = ref_add(32, ra, rb, rsub, rci);
            run_narrow(ra[31:0], rb[31:0], rsub, rci, 5'(i), lat);
            check("narrow_rand_s", n_out_s, r.s);
            check("narrow_rand_flags", {n_out_co, n_out_ov, n_out_zero}, {r.co, r.ov, r.zero});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
